// File: rtl/rv_regfile_pkg.sv
// Shared types and helpers for the integer register file with scoreboard.
// Holds default sizes, the register word type and port-slice helpers.
package rv_regfile_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;

   typedef logic [XLEN_DEFAULT-1:0] word_t;

   // Address width for n registers (at least one bit)
   function automatic int addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Low bit of read port k inside the flattened address bus
   function automatic int aslice(input int k, input int aw);
      return k * aw;
   endfunction

   // Low bit of read port k inside the flattened data bus
   function automatic int dslice(input int k, input int xlen);
      return k * xlen;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservations set, writeback releases clear.
// Ports: clk, rst_n, wr_*_i, rsv_*_i, rd_addr_i in; rsv_ok_o, busy_count_o, port_busy_o out.
module regfile_scoreboard
   import rv_regfile_pkg::*;
#(
   parameter  int NREGS = NREGS_DEFAULT,
   parameter  int NRD   = 2,
   localparam int AW    = addr_w(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic              wr_release_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic              rsv_en_i,
   input  logic [AW-1:0]     rsv_addr_i,
   input  logic [NRD*AW-1:0] rd_addr_i,
   output logic              rsv_ok_o,
   output logic [AW:0]       busy_count_o,
   output logic [NRD-1:0]    port_busy_o
);

   localparam logic [NREGS-1:0] ONE = NREGS'(1);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] busy_eff, rel_mask, rsv_mask;
   logic [AW:0]      cnt_q, cnt_d;
   logic             rel, rsv_ok, dec;

   // A same-cycle release counts as already cleared, so a reservation
   // in the same cycle wins and the bit stays set with no net count change.
   always_comb begin
      rel      = wr_en_i && wr_release_i && (wr_addr_i != '0);
      rel_mask = rel ? (ONE << wr_addr_i) : '0;
      busy_eff = busy_q & ~rel_mask;
      rsv_ok   = rsv_en_i && (rsv_addr_i != '0) && !busy_eff[rsv_addr_i];
      rsv_mask = rsv_ok ? (ONE << rsv_addr_i) : '0;
      busy_d   = busy_eff | rsv_mask;
      dec      = rel && busy_q[wr_addr_i];
      cnt_d    = cnt_q + {{AW{1'b0}}, rsv_ok} - {{AW{1'b0}}, dec};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_port
      assign port_busy_o[k] = busy_q[rd_addr_i[aslice(k, AW) +: AW]];
   end

   assign rsv_ok_o     = rsv_ok;
   assign busy_count_o = cnt_q;

endmodule

// File: rtl/rv_regfile_sb.sv
// Integer register file with NRD combinational reads, one write port and
// a reservation scoreboard. Optional same-cycle bypass: REGFILE_BYPASS_EN.
// Ports: rd_addr/rd_data/rd_busy per port, wr_*, rsv_en/rsv_addr/rsv_ok, busy_count.
module rv_regfile_sb
   import rv_regfile_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEFAULT,
   parameter  int NREGS = NREGS_DEFAULT,
   parameter  int NRD   = 2,
   localparam int AW    = addr_w(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                wr_release,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic                rsv_ok,
   output logic [AW:0]         busy_count
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [NRD-1:0]  port_busy;

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_sb (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (wr_en),
      .wr_release_i (wr_release),
      .wr_addr_i    (wr_addr),
      .rsv_en_i     (rsv_en),
      .rsv_addr_i   (rsv_addr),
      .rd_addr_i    (rd_addr),
      .rsv_ok_o     (rsv_ok),
      .busy_count_o (busy_count),
      .port_busy_o  (port_busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en && (wr_addr != '0)) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] q;

      assign a = rd_addr[aslice(k, AW) +: AW];
      assign q = (a == '0) ? '0 : regs_q[a];

`ifdef REGFILE_BYPASS_EN
      logic hit;
      assign hit = wr_en && (wr_addr != '0) && (wr_addr == a);
      assign rd_data[dslice(k, XLEN) +: XLEN] = hit ? wr_data : q;
      assign rd_busy[k] = port_busy[k] && !(hit && wr_release);
`else
      assign rd_data[dslice(k, XLEN) +: XLEN] = q;
      assign rd_busy[k] = port_busy[k];
`endif
   end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Self-checking bench for rv_regfile_sb (default 32x32, two read ports).
// Expected values are queued at stimulus time and popped at compare time.
module tb_rv_regfile_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                wr_release;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                rsv_ok;
   logic [AW:0]         busy_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] e;

   rv_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_release (wr_release),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .rsv_ok     (rsv_ok),
      .busy_count (busy_count)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_release = 0; wr_addr = '0; wr_data = '0;
      rsv_en = 0; rsv_addr = '0;
   endtask

   task automatic test_reset();
      rst_n = 0; rd_addr = '0; idle();
      rsv_en = 1; rsv_addr = 5'd3;
      #2;
      checks++;
      if (rsv_ok !== 1'b1) begin
         errors++; $display("FAIL rst_rsv_ok got %0b want 1", rsv_ok);
      end
      rsv_addr = 5'd0;
      #1;
      checks++;
      if (rsv_ok !== 1'b0) begin
         errors++; $display("FAIL rst_rsv_x0 got %0b want 0", rsv_ok);
      end
      idle();
      cyc(); cyc();
      rst_n = 1;
      cyc();
      // write x5 and reserve x6, then reset mid-cycle
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
      rsv_en = 1; rsv_addr = 6;
      exp_q.push_back(32'hDEADBEEF);
      cyc(); idle();
      rd_addr = {5'd6, 5'd5};
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[31:0] !== e || busy_count !== 6'd1 || rd_busy !== 2'b10) begin
         errors++;
         $display("FAIL pre_rst got %h/%0d/%b want %h/1/10", rd_data[31:0], busy_count, rd_busy, e);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if (rd_data !== '0 || busy_count !== '0 || rd_busy !== '0) begin
         errors++;
         $display("FAIL async_rst got %h/%0d/%b want 0/0/00", rd_data, busy_count, rd_busy);
      end
      #1 rst_n = 1;
      cyc();
      wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
      cyc(); idle();
      rd_addr = '0;
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== '0) begin
         errors++; $display("FAIL x0_write got %h want 0", rd_data);
      end
   endtask

   task automatic test_rw();
      wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5;
      cyc();
      wr_addr = 31; wr_data = 32'h5A5A5A5A;
      cyc(); idle();
      rd_addr = {5'd31, 5'd3};
      exp_q.push_back(32'hA5A5A5A5);
      exp_q.push_back(32'h5A5A5A5A);
      #1;
      for (int k = 0; k < NRD; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (rd_data[k*XLEN +: XLEN] !== e) begin
            errors++;
            $display("FAIL rw_port%0d got %h want %h", k, rd_data[k*XLEN +: XLEN], e);
         end
      end
      rd_addr = {5'd3, 5'd31};
      exp_q.push_back(32'h5A5A5A5A);
      exp_q.push_back(32'hA5A5A5A5);
      #1;
      for (int k = 0; k < NRD; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (rd_data[k*XLEN +: XLEN] !== e) begin
            errors++;
            $display("FAIL rw_swap%0d got %h want %h", k, rd_data[k*XLEN +: XLEN], e);
         end
      end
   endtask

   task automatic test_reserve();
      rd_addr = {5'd8, 5'd7};
      rsv_en = 1; rsv_addr = 7;
      #1;
      checks++;
      if (rsv_ok !== 1'b1) begin
         errors++; $display("FAIL rsv7_ok got %0b want 1", rsv_ok);
      end
      cyc();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || busy_count !== 6'd1 || rsv_ok !== 1'b0) begin
         errors++;
         $display("FAIL rsv7_waw got %b/%0d/%0b want 1/1/0", rd_busy[0], busy_count, rsv_ok);
      end
      cyc(); idle();
      checks++;
      if (busy_count !== 6'd1) begin
         errors++; $display("FAIL rsv7_cnt got %0d want 1", busy_count);
      end
      wr_en = 1; wr_release = 1; wr_addr = 7; wr_data = 32'h42;
      exp_q.push_back(32'h42);
      cyc(); idle();
      e = exp_q.pop_front();
      checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== e || busy_count !== '0) begin
         errors++;
         $display("FAIL rel7 got %b/%h/%0d want 0/%h/0", rd_busy[0], rd_data[31:0], busy_count, e);
      end
      // release of a register that is not busy
      wr_en = 1; wr_release = 1; wr_addr = 7; wr_data = 32'h43;
      cyc(); idle();
      checks++;
      if (busy_count !== '0 || rd_data[31:0] !== 32'h43) begin
         errors++;
         $display("FAIL rel_idle got %0d/%h want 0/43", busy_count, rd_data[31:0]);
      end
      // release without wr_en is ignored
      rsv_en = 1; rsv_addr = 8;
      cyc(); idle();
      wr_release = 1; wr_addr = 8;
      cyc(); idle();
      checks++;
      if (rd_busy[1] !== 1'b1 || busy_count !== 6'd1) begin
         errors++;
         $display("FAIL rel_no_en got %b/%0d want 1/1", rd_busy[1], busy_count);
      end
      wr_en = 1; wr_release = 1; wr_addr = 8; wr_data = 32'h8;
      cyc(); idle();
      checks++;
      if (rd_busy[1] !== 1'b0 || busy_count !== '0) begin
         errors++;
         $display("FAIL rel8 got %b/%0d want 0/0", rd_busy[1], busy_count);
      end
   endtask

   task automatic test_simul();
      rd_addr = {5'd9, 5'd9};
      rsv_en = 1; rsv_addr = 9;
      cyc(); idle();
      wr_en = 1; wr_release = 1; wr_addr = 9; wr_data = 32'h99;
      rsv_en = 1; rsv_addr = 9;
      exp_q.push_back(32'h99);
      #1;
      checks++;
      if (rsv_ok !== 1'b1) begin
         errors++; $display("FAIL simul_ok got %0b want 1", rsv_ok);
      end
      cyc(); idle();
      e = exp_q.pop_front();
      checks++;
      if (rd_busy !== 2'b11 || busy_count !== 6'd1 || rd_data[63:32] !== e) begin
         errors++;
         $display("FAIL simul_keep got %b/%0d/%h want 11/1/%h", rd_busy, busy_count, rd_data[63:32], e);
      end
      wr_en = 1; wr_release = 1; wr_addr = 9; wr_data = 32'h9A;
      cyc(); idle();
      checks++;
      if (rd_busy !== 2'b00 || busy_count !== '0) begin
         errors++;
         $display("FAIL simul_rel got %b/%0d want 00/0", rd_busy, busy_count);
      end
   endtask

   task automatic test_bypass();
      rd_addr = {5'd12, 5'd12};
      wr_en = 1; wr_addr = 12; wr_data = 32'h11;
      cyc(); idle();
      rsv_en = 1; rsv_addr = 12;
      cyc(); idle();
      wr_en = 1; wr_release = 1; wr_addr = 12; wr_data = 32'h77;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'h77);
      exp_q.push_back(32'h77);
`else
      exp_q.push_back(32'h11);
      exp_q.push_back(32'h11);
`endif
      #1;
      for (int k = 0; k < NRD; k++) begin
         e = exp_q.pop_front();
         checks++;
`ifdef REGFILE_BYPASS_EN
         if (rd_data[k*XLEN +: XLEN] !== e || rd_busy[k] !== 1'b0) begin
`else
         if (rd_data[k*XLEN +: XLEN] !== e || rd_busy[k] !== 1'b1) begin
`endif
            errors++;
            $display("FAIL byp_same%0d got %h/%b want %h", k, rd_data[k*XLEN +: XLEN], rd_busy[k], e);
         end
      end
      cyc(); idle();
      checks++;
      if (rd_data !== {2{32'h77}} || rd_busy !== 2'b00 || busy_count !== '0) begin
         errors++;
         $display("FAIL byp_next got %h/%b/%0d want 77/00/0", rd_data, rd_busy, busy_count);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      for (int i = 1; i < NREGS; i++) begin
         rsv_en = 1; rsv_addr = AW'(i);
         #1;
         if (rsv_ok !== 1'b1) bad++;
         cyc();
      end
      idle();
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL fill_ok got %0d refusals want 0", bad);
      end
      checks++;
      if (busy_count !== 6'd31) begin
         errors++; $display("FAIL fill_cnt got %0d want 31", busy_count);
      end
      rsv_en = 1; rsv_addr = 0;
      #1;
      checks++;
      if (rsv_ok !== 1'b0) begin
         errors++; $display("FAIL fill_x0 got %0b want 0", rsv_ok);
      end
      rsv_addr = 17;
      #1;
      checks++;
      if (rsv_ok !== 1'b0) begin
         errors++; $display("FAIL fill_waw got %0b want 0", rsv_ok);
      end
      idle();
      for (int i = 1; i < NREGS; i++) begin
         wr_en = 1; wr_release = 1; wr_addr = AW'(i);
         wr_data = 32'h1000 + i * 3;
         exp_q.push_back(32'h1000 + i * 3);
         cyc();
         if (i == 16) begin
            checks++;
            if (busy_count !== 6'd15) begin
               errors++; $display("FAIL drain_mid got %0d want 15", busy_count);
            end
         end
      end
      idle();
      checks++;
      if (busy_count !== '0) begin
         errors++; $display("FAIL drain_cnt got %0d want 0", busy_count);
      end
      bad = 0;
      for (int i = 1; i < NREGS; i++) begin
         rd_addr = {AW'(i), AW'(NREGS - i)};
         #1;
         e = exp_q.pop_front();
         if (rd_data[63:32] !== e || rd_data[31:0] !== 32'h1000 + (NREGS - i) * 3 ||
             rd_busy !== 2'b00) begin
            bad++;
            $display("FAIL drain_rd x%0d got %h want %h", i, rd_data[63:32], e);
         end
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL drain_data got %0d bad reads want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_rw();
      test_reserve();
      test_simul();
      test_bypass();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
